// File: rtl/seg7_scan_if.sv
// Display-side signal bundle for seg7_scan: display word, live masks, decoder loop and drive outputs.
// master = surrounding logic/board, slave = seg7_scan.
interface seg7_scan_if;
    logic [31:0] data;
    logic [7:0]  dp_mask;
    logic [7:0]  digit_en;
    logic [3:0]  hex_out;
    logic [7:0]  seg_in;
    logic [7:0]  an;
    logic [7:0]  seg_n;
    logic        frame_tick;

    modport master (
        output data, dp_mask, digit_en, seg_in,
        input  hex_out, an, seg_n, frame_tick
    );

    modport slave (
        input  data, dp_mask, digit_en, seg_in,
        output hex_out, an, seg_n, frame_tick
    );
endinterface

// File: rtl/seg7_scan.sv
// Scans an 8-digit common-anode display: latches one word per frame, BLANK/SHOW per digit.
// Drive outputs lag the FSM by one cycle; no backpressure, free-running scan.
module seg7_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [31:0]   shadow;
    logic [7:0]    an_q, an_nxt;
    logic [7:0]    seg_q, seg_nxt;
    logic          tick_q;
    logic          latch;
    logic          unused_seg7;

    assign unused_seg7 = bus.seg_in[7];

    // Nibble is presented for the whole digit period so the decoder settles during BLANK.
    assign bus.hex_out    = shadow[{idx, 2'b00} +: 4];
    assign bus.an         = an_q;
    assign bus.seg_n      = seg_q;
    assign bus.frame_tick = tick_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        an_nxt    = 8'hFF;
        seg_nxt   = 8'hFF;
        latch     = (state == BLANK) && (idx == 3'd0) && (cnt == '0);

        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end
            end
            SHOW: begin
                if (cnt == SCAN_LAST) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 3'd1;
                end
                seg_nxt = ~{bus.dp_mask[idx], bus.seg_in[6:0]};
                if (bus.digit_en[idx]) begin
                    an_nxt = ~(8'b1 << idx);
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= BLANK;
            cnt    <= '0;
            idx    <= 3'd0;
            shadow <= 32'h0;
            an_q   <= 8'hFF;
            seg_q  <= 8'hFF;
            tick_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            an_q   <= an_nxt;
            seg_q  <= seg_nxt;
            tick_q <= latch;
            if (latch) begin
                shadow <= bus.data;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (SCAN_DIV=4, BLANK_CYC=2) with a hex-to-segment decoder in the loop.
module tb_seg7_scan;
    logic clk = 1'b0;
    logic rst;

    seg7_scan_if ifc ();

    seg7_scan #(.SCAN_DIV(4), .BLANK_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    // Bit 7 driven high: the DUT must ignore it.
    assign ifc.seg_in = {1'b1, hex7(ifc.hex_out)};

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       ft;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Hand-computed drive for word 32'h1234ABCD, digits 0..7 = D,C,B,A,4,3,2,1
    logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] seg_tab [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    task automatic step(input logic [7:0] e_an, input logic [7:0] e_seg, input logic e_ft);
        exp_t e;
        e.an = e_an; e.seg = e_seg; e.ft = e_ft;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic digit_period(input logic [7:0] e_an, input logic [7:0] e_seg, input logic e_ft);
        step(8'hFF, 8'hFF, e_ft);
        step(8'hFF, 8'hFF, 1'b0);
        repeat (4) step(e_an, e_seg, 1'b0);
    endtask

    task automatic normal_digits(input int from, input int to);
        for (int d = from; d <= to; d++)
            digit_period(an_tab[d], seg_tab[d], d == 0);
    endtask

    // Monitor: one expected entry per cycle, plus anode-safety checks on every sample.
    logic [7:0] prev_an;
    logic       started = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (ifc.an !== e.an) begin
                errors++;
                $display("FAIL an at %0t: got %h want %h", $time, ifc.an, e.an);
            end
            checks++;
            if (ifc.seg_n !== e.seg) begin
                errors++;
                $display("FAIL seg_n at %0t: got %h want %h", $time, ifc.seg_n, e.seg);
            end
            checks++;
            if (ifc.frame_tick !== e.ft) begin
                errors++;
                $display("FAIL frame_tick at %0t: got %b want %b", $time, ifc.frame_tick, e.ft);
            end
            if (started) begin
                checks++;
                if ($countones(~ifc.an) > 1) begin
                    errors++;
                    $display("FAIL an_onehot at %0t: got %h want at most one low bit", $time, ifc.an);
                end
                checks++;
                if (prev_an != 8'hFF && ifc.an != 8'hFF && prev_an != ifc.an) begin
                    errors++;
                    $display("FAIL an_gap at %0t: got %h after %h want FF between digits",
                             $time, ifc.an, prev_an);
                end
            end
            prev_an = ifc.an;
            started = 1'b1;
        end
    end

    initial begin
        rst          = 1'b1;
        ifc.data     = 32'h1234ABCD;
        ifc.dp_mask  = 8'h00;
        ifc.digit_en = 8'hFF;
        repeat (3) step(8'hFF, 8'hFF, 1'b0);
        rst = 1'b0;

        // Frame 1: first word latched on the edge after release
        normal_digits(0, 7);

        // Frame 2: data changes mid-frame, remaining digits keep the old word
        normal_digits(0, 3);
        ifc.data = 32'hFFFFFFFF;
        normal_digits(4, 7);

        // Frame 3: new word shows everywhere; restore data mid-frame without effect
        digit_period(8'hFE, 8'h8E, 1'b1);
        ifc.data = 32'h1234ABCD;
        for (int d = 1; d < 8; d++)
            digit_period(an_tab[d], 8'h8E, 1'b0);

        // Frame 4: digit 0 disabled with decimal point, cathodes still driven
        ifc.dp_mask  = 8'h01;
        ifc.digit_en = 8'hFE;
        digit_period(8'hFF, 8'h21, 1'b1);
        ifc.dp_mask  = 8'h00;
        ifc.digit_en = 8'hFF;
        normal_digits(1, 7);

        // Frame 5: one-cycle reset while digit 5 is lit
        normal_digits(0, 4);
        step(8'hFF, 8'hFF, 1'b0);
        step(8'hFF, 8'hFF, 1'b0);
        step(8'hDF, 8'hB0, 1'b0);
        step(8'hDF, 8'hB0, 1'b0);
        rst = 1'b1;
        step(8'hFF, 8'hFF, 1'b0);
        rst = 1'b0;

        // Restarted scan from digit 0, then one more full frame
        normal_digits(0, 7);
        normal_digits(0, 7);

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
